mmio_uart_tx: RTL and testbench

//   Memory-mapped UART transmitter on the core data-store bus, downstream of ayatsuki_core, in parallel with the data RAM.

---
 rtl/mmio_uart_tx_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared bus widths, register offsets and serializer state encodings for mmio_uart_tx.
// Optional even-parity frame is selected with the UART_TX_PARITY_EN macro.
package mmio_uart_tx_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;

    localparam logic [MEM_ADDR_W-1:0] UART_TXDATA_OFS = 32'd0;
    localparam logic [MEM_ADDR_W-1:0] UART_STATUS_OFS = 32'd4;

    localparam logic [2:0] UART_S_IDLE   = 3'd0;
    localparam logic [2:0] UART_S_START  = 3'd1;
    localparam logic [2:0] UART_S_DATA   = 3'd2;
    localparam logic [2:0] UART_S_PARITY = 3'd3;
    localparam logic [2:0] UART_S_STOP   = 3'd4;

    typedef struct packed {
        logic [3:0] count;
        logic       overflow;
        logic       full;
        logic       empty;
        logic       busy;
    } uart_status_t;

    function automatic logic [DATA_W-1:0] pack_status(input uart_status_t s);
        return {{(DATA_W - 8){1'b0}}, s};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; head is combinational from the read pointer.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == 4'(DEPTH));
    assign empty_o = (count_q == 4'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + 4'(push_ok) - 4'(pop_ok);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA store pushes a byte, STATUS load returns FIFO/FSM state.
// Define UART_TX_PARITY_EN for an 8E1 frame; default build sends 8N1.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR    = 32'h0000_0800,
    parameter int unsigned           CLKS_PER_BIT = 434,
    parameter int unsigned           FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_w_enable_i,
    input  logic [MEM_ADDR_W-1:0] mem_w_addr_i,
    input  logic [DATA_W-1:0]     mem_w_data_i,
    input  logic                  mem_r_enable_i,
    input  logic [MEM_ADDR_W-1:0] mem_r_addr_i,
    output logic [DATA_W-1:0]     mem_r_data_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int unsigned        BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        data_q, data_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic       wr_hit, rd_hit, ovf_event, baud_wrap, pop;
    logic [7:0] fifo_head;
    logic       fifo_full, fifo_empty;
    logic [3:0] fifo_count;
    uart_status_t status;

    logic unused_wdata;
    assign unused_wdata = ^mem_w_data_i[DATA_W-1:8];

    assign wr_hit = mem_w_enable_i && (mem_w_addr_i == BASE_ADDR + UART_TXDATA_OFS);
    assign rd_hit = mem_r_enable_i && (mem_r_addr_i == BASE_ADDR + UART_STATUS_OFS);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_hit),
        .push_data_i (mem_w_data_i[7:0]),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Mirrors the FIFO's accept rule: a full push is only lost when nothing pops.
    assign ovf_event = wr_hit && fifo_full && !pop;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop       = 1'b0;

        if (state_q != UART_S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            UART_S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_head;
                    baud_d  = '0;
                    state_d = UART_S_START;
                end
            end
            UART_S_START: begin
                if (baud_wrap) begin
                    bit_idx_d = 3'd0;
                    state_d   = UART_S_DATA;
                end
            end
            UART_S_DATA: begin
                if (baud_wrap) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_S_PARITY;
`else
                        state_d = UART_S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            UART_S_PARITY: begin
                if (baud_wrap) begin
                    state_d = UART_S_STOP;
                end
            end
            UART_S_STOP: begin
                if (baud_wrap) begin
                    // Chain straight into the next frame when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_head;
                        state_d = UART_S_START;
                    end else begin
                        state_d = UART_S_IDLE;
                    end
                end
            end
            default: begin
                state_d = UART_S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is derived from the next state so tx_o stays a clean register output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            UART_S_START:  tx_d = 1'b0;
            UART_S_DATA:   tx_d = data_d[bit_idx_d];
            UART_S_PARITY: tx_d = ^data_d;
            default:       tx_d = 1'b1;
        endcase
    end

    always_comb begin
        status.count    = fifo_count;
        status.overflow = ovf_q;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.busy     = busy_o;

        rd_data_d = rd_hit ? pack_status(status) : '0;

        ovf_d = ovf_q;
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (rd_hit) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'd0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy_o       = (state_q != UART_S_IDLE);
    assign tx_o         = tx_q;
    assign mem_r_data_o = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: waveform-level reference model plus directed literal checks.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_0800;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic [31:0] r_addr = '0;
    logic [31:0] r_data;
    logic        tx;
    logic        busy;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_w_enable_i (w_en),
        .mem_w_addr_i   (w_addr),
        .mem_w_data_i   (w_data),
        .mem_r_enable_i (r_en),
        .mem_r_addr_i   (r_addr),
        .mem_r_data_o   (r_data),
        .tx_o           (tx),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: bytes queue plus the expected line waveform, one entry per cycle.
    logic [7:0]  mq[$];
    logic        mwave[$];
    logic        m_ovf = 1'b0;
    logic        exp_tx = 1'b1;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_rdata = '0;

    function automatic logic frame_level(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && FRAME_BITS == 11) return ^b;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit         pop, rd, ovf_ev;
        logic [7:0] b;
        cyc++;
        if (rst) begin
            started = 1'b1;
            mq.delete();
            mwave.delete();
            m_ovf     = 1'b0;
            exp_tx    = 1'b1;
            exp_busy  = 1'b0;
            exp_rdata = '0;
        end else begin
            rd = r_en && (r_addr == BASE + 32'd4);
            exp_rdata = rd ? {24'b0, 4'(mq.size()), m_ovf, (mq.size() == DEPTH),
                              (mq.size() == 0), exp_busy} : 32'd0;
            pop = (mq.size() != 0) && (mwave.size() == 0);
            b = 8'd0;
            if (pop) b = mq.pop_front();
            ovf_ev = 1'b0;
            if (w_en && w_addr == BASE) begin
                if (mq.size() < DEPTH) mq.push_back(w_data[7:0]);
                else ovf_ev = 1'b1;
            end
            if (ovf_ev) m_ovf = 1'b1;
            else if (rd) m_ovf = 1'b0;
            if (pop) begin
                for (int k = 0; k < FRAME_BITS; k++) begin
                    for (int c = 0; c < CPB; c++) mwave.push_back(frame_level(b, k));
                end
            end
            if (mwave.size() != 0) begin
                exp_tx   = mwave.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_tx_o", 32'(tx), 32'(exp_tx));
            chk("model_busy_o", 32'(busy), 32'(exp_busy));
            chk("model_rdata", r_data, exp_rdata);
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, output int n);
        n = cyc;
        w_en = 1'b1;
        w_addr = a;
        w_data = d;
        @(posedge clk);
        #1 w_en = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        r_en = 1'b1;
        r_addr = a;
        @(posedge clk);
        #1 r_en = 1'b0;
        @(negedge clk);
    endtask

    // Advance to the falling edge inside cycle t; overshooting is reported as a failure.
    task automatic goto_cycle(input int t);
        while (!(cyc == t && clk == 1'b0)) begin
            if (cyc > t) begin
                n_vec++;
                n_err++;
                $display("FAIL goto_cycle: at cycle %0d, required %0d", cyc, t);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d, required finish before time limit", cyc);
        $fatal(1);
    end

    initial begin
        int n, n2;
        int a5_bits [8];
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdata", r_data, 32'd0);

        // 1: single byte 0xA5
        store(BASE, 32'h0000_00A5, n);
        goto_cycle(n + 2);
        chk("t1_start_first", 32'(tx), 32'd0);
        goto_cycle(n + 5);
        chk("t1_start_last", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            goto_cycle(n + 6 + 4 * i);
            chk("t1_data_first", 32'(tx), 32'(a5_bits[i]));
            goto_cycle(n + 9 + 4 * i);
            chk("t1_data_last", 32'(tx), 32'(a5_bits[i]));
        end
        goto_cycle(n + 1 + FRAME);
        chk("t1_stop", 32'(tx), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd1);
        goto_cycle(n + 2 + FRAME);
        chk("t1_busy_drop", 32'(busy), 32'd0);

        // 2: three back-to-back frames
        store(BASE, 32'h11, n);
        store(BASE, 32'h22, n2);
        store(BASE, 32'h33, n2);
        goto_cycle(n + 2 + FRAME);
        chk("t2_start2", 32'(tx), 32'd0);
        chk("t2_busy2", 32'(busy), 32'd1);
        goto_cycle(n + 2 + 2 * FRAME);
        chk("t2_start3", 32'(tx), 32'd0);
        goto_cycle(n + 1 + 3 * FRAME);
        chk("t2_busy_last", 32'(busy), 32'd1);
        goto_cycle(n + 2 + 3 * FRAME);
        chk("t2_busy_drop", 32'(busy), 32'd0);
        load(BASE + 32'd4);
        chk("t2_status", r_data, 32'h0000_0002);

        // 3: overflow with six stores into a depth-4 FIFO
        store(BASE, 32'h01, n);
        for (int i = 2; i <= 6; i++) store(BASE, 32'(i), n2);
        load(BASE + 32'd4);
        chk("t3_status_ovf", r_data, 32'h0000_004D);
        load(BASE + 32'd4);
        chk("t3_status_clr", r_data, 32'h0000_0045);
        goto_cycle(n + 1 + 5 * FRAME);
        chk("t3_busy_last", 32'(busy), 32'd1);
        goto_cycle(n + 2 + 5 * FRAME);
        chk("t3_busy_drop", 32'(busy), 32'd0);

        // 4: reset mid-DATA aborts the frame and flushes the queued byte
        store(BASE, 32'h5A, n);
        store(BASE, 32'h3C, n2);
        goto_cycle(n + 10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_tx_after_rst", 32'(tx), 32'd1);
        chk("t4_busy_after_rst", 32'(busy), 32'd0);
        chk("t4_rdata_after_rst", r_data, 32'd0);
        load(BASE + 32'd4);
        chk("t4_status", r_data, 32'h0000_0002);
        goto_cycle(n + 12 + 2 * FRAME);
        chk("t4_no_start", 32'(tx), 32'd1);

        // 5: store to BASE+8 with a simultaneous load from BASE
        n = cyc;
        w_en = 1'b1;
        w_addr = BASE + 32'd8;
        w_data = 32'h77;
        r_en = 1'b1;
        r_addr = BASE;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        chk("t5_rdata", r_data, 32'd0);
        goto_cycle(n + 4);
        chk("t5_tx_idle", 32'(tx), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        load(BASE + 32'd4);
        chk("t5_status", r_data, 32'h0000_0002);

        // 6: 0x07 frame length and parity/stop slot
        store(BASE, 32'h07, n);
        goto_cycle(n + 2);
        chk("t6_start", 32'(tx), 32'd0);
        goto_cycle(n + 2 + 9 * CPB);
        chk("t6_bit9_slot", 32'(tx), 32'd1);
        goto_cycle(n + 1 + FRAME);
        chk("t6_busy_last", 32'(busy), 32'd1);
        goto_cycle(n + 2 + FRAME);
        chk("t6_busy_drop", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
